// File: rtl/alu_io_pkg.sv
// Shared definitions for the ALU I/O responder.
// Holds the FSM state encoding, ALU opcodes, the io_in/io_out field positions
// and the constant pad output-enable pattern.
package alu_io_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_COMPUTE = 2'd2,
        ST_HOLD    = 2'd3
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    localparam int IN_W  = 20;
    localparam int OUT_W = 15;
    localparam int OEB_W = 38;

    // io_in = {sel2, sel1, B1, A1, B0, A0}
    localparam int IN_A0_LSB   = 0;
    localparam int IN_B0_LSB   = 4;
    localparam int IN_A1_LSB   = 8;
    localparam int IN_B1_LSB   = 12;
    localparam int IN_SEL1_LSB = 16;
    localparam int IN_SEL2_LSB = 18;

    // io_out = {seq, R1, R0, valid}
    localparam int OUT_VALID_BIT = 0;
    localparam int OUT_R0_LSB    = 1;
    localparam int OUT_R1_LSB    = 6;
    localparam int OUT_SEQ_LSB   = 11;

    // Pads 0 and 4..17 are outputs (oeb = 0); every other pad is an input.
    localparam logic [OEB_W-1:0] IO_OEB_CONST = 38'h3F_FFFC_000E;

endpackage

// File: rtl/alu4.sv
// Combinational 4-bit ALU lane.
// Ports:
//   i_a, i_b : 4-bit operands
//   i_sel    : opcode (add / subtract / and / xor)
//   o_r      : 5-bit result; bit 4 is carry for add, borrow for subtract
module alu4
    import alu_io_pkg::*;
(
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic [1:0] i_sel,
    output logic [4:0] o_r
);

    always_comb begin
        o_r = '0;
        case (i_sel)
            OP_ADD:  o_r = {1'b0, i_a} + {1'b0, i_b};
            // 5-bit wraparound leaves bit 4 set exactly when a borrow occurs
            OP_SUB:  o_r = {1'b0, i_a} - {1'b0, i_b};
            OP_AND:  o_r = {1'b0, i_a & i_b};
            OP_XOR:  o_r = {1'b0, i_a ^ i_b};
            default: o_r = '0;
        endcase
    end

endmodule

// File: rtl/alu_io_responder.sv
// Pad-facing dual-lane ALU responder.
// Synchronizes a 20-bit operand word, waits for it to be stable for
// STABLE_CYCLES samples, computes two 4-bit ALU results once, and presents
// them with a sequence number and a valid flag until the input changes.
// Ports:
//   clock  : system clock, rising edge
//   resetb : asynchronous active-low reset
//   io_in  : operand word {sel2, sel1, B1, A1, B0, A0}
//   io_out : result word {seq[3:0], R1[4:0], R0[4:0], valid}
//   io_oeb : constant pad output-enable bar
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | one cycle after reset, stable counter held at 0
// SETTLE  | counting consecutive identical synchronized samples
// COMPUTE | single cycle: latch both results, bump seq
// HOLD    | valid asserted until the synchronized word leaves the accepted one
module alu_io_responder
    import alu_io_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic              clock,
    input  logic              resetb,
    input  logic [IN_W-1:0]   io_in,
    output logic [OUT_W-1:0]  io_out,
    output logic [OEB_W-1:0]  io_oeb
);

    // The counter holds the number of sample-to-sample matches, so N identical
    // samples correspond to N-1 matches.
    localparam logic [3:0] CNT_TC = 4'(STABLE_CYCLES - 1);

    state_t          r_state;
    state_t          w_state_next;

    logic [IN_W-1:0] r_sync1;
    logic [IN_W-1:0] r_sync2;
    logic [IN_W-1:0] r_prev;
    logic [IN_W-1:0] r_acc;

    logic [3:0]      r_cnt;
    logic [3:0]      w_cnt_next;
    logic [3:0]      w_cnt_load;
    logic            w_same;
    logic            w_latch;
    logic            w_valid_next;

    logic [4:0]      w_r0;
    logic [4:0]      w_r1;
    logic [4:0]      r_r0;
    logic [4:0]      r_r1;
    logic [3:0]      r_seq;
    logic            r_valid;

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= io_in;
            r_sync2 <= r_sync1;
        end
    end

    // r_prev is the previous synchronized sample. On entry to COMPUTE it
    // holds exactly the sample that satisfied the stability count, so the
    // ALUs and the accepted-word register both take their operands from it.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_prev <= '0;
        end else begin
            r_prev <= r_sync2;
        end
    end

    assign w_same     = (r_sync2 == r_prev);
    assign w_cnt_next = w_same ? (r_cnt + 4'd1) : 4'd0;

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:    w_state_next = ST_SETTLE;
            // >= so that STABLE_CYCLES = 1 accepts on any single sample
            ST_SETTLE:  if (w_cnt_next >= CNT_TC) w_state_next = ST_COMPUTE;
            ST_COMPUTE: w_state_next = ST_HOLD;
            ST_HOLD:    if (r_sync2 != r_acc) w_state_next = ST_SETTLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_latch      = (r_state == ST_COMPUTE);
        w_valid_next = (w_state_next == ST_HOLD);
        w_cnt_load   = (r_state == ST_SETTLE) ? w_cnt_next : 4'd0;
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_load;
        end
    end

    alu4 u_alu_lane0 (
        .i_a   (r_prev[IN_A0_LSB   +: 4]),
        .i_b   (r_prev[IN_B0_LSB   +: 4]),
        .i_sel (r_prev[IN_SEL1_LSB +: 2]),
        .o_r   (w_r0)
    );

    alu4 u_alu_lane1 (
        .i_a   (r_prev[IN_A1_LSB   +: 4]),
        .i_b   (r_prev[IN_B1_LSB   +: 4]),
        .i_sel (r_prev[IN_SEL2_LSB +: 2]),
        .o_r   (w_r1)
    );

    // Results and seq only move in COMPUTE; SETTLE keeps the last ones visible
    // with valid low.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_r0    <= '0;
            r_r1    <= '0;
            r_seq   <= '0;
            r_acc   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_valid_next;
            if (w_latch) begin
                r_r0  <= w_r0;
                r_r1  <= w_r1;
                r_seq <= r_seq + 4'd1;
                r_acc <= r_prev;
            end
        end
    end

    assign io_out[OUT_VALID_BIT]     = r_valid;
    assign io_out[OUT_R0_LSB  +: 5]  = r_r0;
    assign io_out[OUT_R1_LSB  +: 5]  = r_r1;
    assign io_out[OUT_SEQ_LSB +: 4]  = r_seq;

    assign io_oeb = IO_OEB_CONST;

endmodule
